// File: rtl/hazard_forward_ctrl.sv
// ID-stage hazard controller: operand forwarding, load-use and scoreboard stalls,
// long-op scoreboard, and register-file write-port arbitration (WB over completions).
package forwarding;
  typedef struct packed {
    logic        data_valid;
    logic [31:0] data;
    logic [4:0]  address;
  } t;
endpackage

module hfc_src_resolve (
  input  logic [4:0]   rs,
  input  logic         used,
  input  forwarding::t ex_fwd,
  input  logic         ex_we,
  input  forwarding::t mem_fwd,
  input  logic         mem_we,
  input  forwarding::t wb_fwd,
  input  logic         grant,
  input  logic [4:0]   cpl_rd,
  input  logic [31:0]  cpl_data,
  input  logic [31:0]  rf_data,
  input  logic         pending,
  output logic [31:0]  op,
  output logic         hazard
);
  logic fwd_unres;
  logic cpl_hit;

  always_comb begin
    op        = rf_data;
    fwd_unres = 1'b0;
    cpl_hit   = grant && (cpl_rd == rs);
    if (rs == 5'd0) begin
      op = '0;
    end else if (ex_we && (ex_fwd.address == rs)) begin
      op        = ex_fwd.data;
      fwd_unres = !ex_fwd.data_valid;
    end else if (mem_we && (mem_fwd.address == rs)) begin
      op        = mem_fwd.data;
      fwd_unres = !mem_fwd.data_valid;
    end else if (wb_fwd.data_valid && (wb_fwd.address == rs)) begin
      op = wb_fwd.data;
    end else if (cpl_hit) begin
      op = cpl_data;
    end
    // A pending long op is satisfied only by its completion landing this very cycle.
    hazard = used && (rs != 5'd0) && (fwd_unres || (pending && !cpl_hit));
  end
endmodule

module hazard_forward_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [4:0]   id_rs1,
  input  logic [4:0]   id_rs2,
  input  logic         id_rs1_used,
  input  logic         id_rs2_used,
  input  logic [4:0]   id_rd,
  input  logic         id_rd_we,
  input  logic         id_long_op,
  input  forwarding::t ex_fwd,
  input  forwarding::t mem_fwd,
  input  logic         ex_we,
  input  logic         mem_we,
  input  forwarding::t wb_fwd,
  input  logic [31:0]  rf_rs1_data,
  input  logic [31:0]  rf_rs2_data,
  input  logic         lo_cpl_valid,
  input  logic [4:0]   lo_cpl_rd,
  input  logic [31:0]  lo_cpl_data,
  output logic         lo_cpl_ready,
  output forwarding::t rf_wr,
  output logic [31:0]  id_op1,
  output logic [31:0]  id_op2,
  output logic         stall_if_id,
  output logic         bubble_ex,
  output logic [31:0]  sb_pending,
  output logic         sb_busy
);
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W   = $clog2(STARVE_LIMIT + 1);

  logic [31:0]      sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q;

  logic grant, dispatch, sb_clr, waw, full, starved;

  logic [NUM_SRC-1:0][4:0]  src_rs;
  logic [NUM_SRC-1:0]       src_used;
  logic [NUM_SRC-1:0][31:0] src_rf;
  logic [NUM_SRC-1:0][31:0] src_op;
  logic [NUM_SRC-1:0]       src_haz;

  assign lo_cpl_ready = !wb_fwd.data_valid;
  assign grant        = lo_cpl_valid && lo_cpl_ready;

  assign src_rs   = {id_rs2, id_rs1};
  assign src_used = {id_rs2_used, id_rs1_used};
  assign src_rf   = {rf_rs2_data, rf_rs1_data};

  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      hfc_src_resolve u_res (
        .rs       (src_rs[g]),
        .used     (src_used[g]),
        .ex_fwd   (ex_fwd),
        .ex_we    (ex_we),
        .mem_fwd  (mem_fwd),
        .mem_we   (mem_we),
        .wb_fwd   (wb_fwd),
        .grant    (grant),
        .cpl_rd   (lo_cpl_rd),
        .cpl_data (lo_cpl_data),
        .rf_data  (src_rf[g]),
        .pending  (sb_q[src_rs[g]]),
        .op       (src_op[g]),
        .hazard   (src_haz[g])
      );
    end
  endgenerate

  assign id_op1 = src_op[0];
  assign id_op2 = src_op[1];

  assign waw     = id_long_op && id_rd_we && (id_rd != 5'd0) && sb_q[id_rd];
  assign full    = id_long_op && (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign starved = (starve_q == STV_W'(STARVE_LIMIT));

  assign stall_if_id = !flush && ((|src_haz) || waw || full || starved);
  assign bubble_ex   = stall_if_id;

  assign dispatch = id_long_op && id_rd_we && (id_rd != 5'd0) && !stall_if_id && !flush;
  assign sb_clr   = grant && sb_q[lo_cpl_rd];

  always_comb begin
    rf_wr = '0;
    if (wb_fwd.data_valid) begin
      rf_wr = wb_fwd;
    end else if (grant) begin
      rf_wr.data_valid = 1'b1;
      rf_wr.data       = lo_cpl_data;
      rf_wr.address    = lo_cpl_rd;
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (sb_clr)   sb_d[lo_cpl_rd] = 1'b0;
    if (dispatch) sb_d[id_rd]     = 1'b1;
    sb_d[0] = 1'b0;
    cnt_d = cnt_q;
    case ({dispatch, sb_clr})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
      if (lo_cpl_valid && !lo_cpl_ready)
        starve_q <= starved ? starve_q : starve_q + STV_W'(1);
      else
        starve_q <= '0;
    end
  end

  assign sb_pending = sb_q;
  assign sb_busy    = |sb_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a rule-level reference model.
module tb_hazard_forward_ctrl;
  localparam int MAXO = 4;
  localparam int SL   = 4;

  logic         clk = 1'b0;
  logic         reset, flush;
  logic [4:0]   id_rs1, id_rs2, id_rd;
  logic         id_rs1_used, id_rs2_used, id_rd_we, id_long_op;
  forwarding::t ex_fwd, mem_fwd, wb_fwd, rf_wr;
  logic         ex_we, mem_we;
  logic [31:0]  rf_rs1_data, rf_rs2_data;
  logic         lo_cpl_valid, lo_cpl_ready;
  logic [4:0]   lo_cpl_rd;
  logic [31:0]  lo_cpl_data;
  logic [31:0]  id_op1, id_op2, sb_pending;
  logic         stall_if_id, bubble_ex, sb_busy;

  int checks = 0;
  int failures = 0;

  hazard_forward_ctrl #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_long_op(id_long_op),
    .ex_fwd(ex_fwd), .mem_fwd(mem_fwd), .ex_we(ex_we), .mem_we(mem_we), .wb_fwd(wb_fwd),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .lo_cpl_valid(lo_cpl_valid), .lo_cpl_rd(lo_cpl_rd), .lo_cpl_data(lo_cpl_data),
    .lo_cpl_ready(lo_cpl_ready), .rf_wr(rf_wr), .id_op1(id_op1), .id_op2(id_op2),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .sb_pending(sb_pending), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic forwarding::t fw(input logic v, input logic [31:0] d, input logic [4:0] a);
    fw.data_valid = v;
    fw.data       = d;
    fw.address    = a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    flush = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_long_op = 0;
    ex_fwd = '0; mem_fwd = '0; wb_fwd = '0; ex_we = 0; mem_we = 0;
    rf_rs1_data = 32'hAAAA0001; rf_rs2_data = 32'hBBBB0002;
    lo_cpl_valid = 0; lo_cpl_rd = 0; lo_cpl_data = 0;
  endtask

  typedef struct {
    logic [4:0]   rs1, rs2;
    logic         u1, u2, fl;
    forwarding::t ex, mem, wb;
    logic         exw, memw;
    logic         cv;
    logic [4:0]   crd;
    logic [31:0]  cd;
    logic [1:0]   opmask;
    logic [31:0]  e_op1, e_op2;
    logic         e_stall, e_ready;
    forwarding::t e_rf;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mkv(
    input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2, input logic fl,
    input forwarding::t ex, input logic exw, input forwarding::t mem, input logic memw,
    input forwarding::t wb, input logic cv, input logic [4:0] crd, input logic [31:0] cd,
    input logic [1:0] opmask, input logic [31:0] e_op1, input logic [31:0] e_op2,
    input logic e_stall, input logic e_ready, input forwarding::t e_rf);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.fl = fl;
    v.ex = ex; v.exw = exw; v.mem = mem; v.memw = memw; v.wb = wb;
    v.cv = cv; v.crd = crd; v.cd = cd; v.opmask = opmask;
    v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_stall = e_stall; v.e_ready = e_ready; v.e_rf = e_rf;
    return v;
  endfunction

  // reference model state
  bit [31:0]  m_pend;
  int         m_cnt, m_starve;
  logic [4:0] m_q[$];
  bit         hold, from_q;

  function automatic void m_opnd(input logic [4:0] rs, input logic [31:0] rfd, input bit grant,
                                 output logic [31:0] val, output bit unres);
    forwarding::t src[4];
    bit           hit[4];
    src[0] = ex_fwd;  hit[0] = ex_we;
    src[1] = mem_fwd; hit[1] = mem_we;
    src[2] = wb_fwd;  hit[2] = wb_fwd.data_valid;
    src[3] = fw(1'b1, lo_cpl_data, lo_cpl_rd); hit[3] = grant;
    val = rfd;
    unres = 0;
    if (rs == 0) begin
      val = 0;
      return;
    end
    for (int i = 3; i >= 0; i--)
      if (hit[i] && src[i].address == rs) begin
        val = src[i].data;
        unres = !src[i].data_valid;
      end
  endfunction

  initial begin
    forwarding::t nul;
    nul = '0;
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    settle();
    chk("rst_stall", stall_if_id, 0);
    chk("rst_bubble", bubble_ex, 0);
    chk("rst_ready", lo_cpl_ready, 1);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_busy", sb_busy, 0);
    chk("rst_pending", sb_pending, 0);
    tick();

    // rs1,u1,rs2,u2,fl, ex,exw, mem,memw, wb, cv,crd,cd, opmask, op1,op2, stall,ready, rf
    tv.push_back(mkv(5,1,0,1,0, fw(1,32'h11,5),1, fw(1,32'h22,5),1, fw(1,32'h33,5), 0,0,0,
                     2'b11, 32'h11, 0, 0,0, fw(1,32'h33,5)));
    tv.push_back(mkv(5,1,0,1,0, fw(1,32'h11,5),0, fw(1,32'h22,5),1, fw(1,32'h33,5), 0,0,0,
                     2'b11, 32'h22, 0, 0,0, fw(1,32'h33,5)));
    tv.push_back(mkv(5,1,0,1,0, fw(1,32'h11,5),0, fw(1,32'h22,5),0, fw(1,32'h33,5), 0,0,0,
                     2'b11, 32'h33, 0, 0,0, fw(1,32'h33,5)));
    tv.push_back(mkv(0,1,0,1,0, fw(1,32'h11,0),1, fw(1,32'h22,0),1, fw(1,32'h33,0), 0,0,0,
                     2'b11, 0, 0, 0,0, fw(1,32'h33,0)));
    tv.push_back(mkv(1,0,7,1,0, fw(0,32'hDEAD,7),1, nul,0, nul, 0,0,0,
                     2'b01, 32'hAAAA0001, 0, 1,1, nul));
    tv.push_back(mkv(1,0,7,0,0, fw(0,32'hDEAD,7),1, nul,0, nul, 0,0,0,
                     2'b01, 32'hAAAA0001, 0, 0,1, nul));
    tv.push_back(mkv(1,0,7,1,1, fw(0,32'hDEAD,7),1, nul,0, nul, 0,0,0,
                     2'b01, 32'hAAAA0001, 0, 0,1, nul));
    tv.push_back(mkv(7,1,0,0,0, nul,0, fw(0,0,7),1, nul, 0,0,0,
                     2'b10, 0, 0, 1,1, nul));
    tv.push_back(mkv(0,1,7,1,0, fw(1,32'h1,8),1, fw(1,32'hABCD,7),1, nul, 0,0,0,
                     2'b11, 0, 32'hABCD, 0,1, nul));
    tv.push_back(mkv(3,1,4,1,0, nul,0, nul,0, nul, 1,3,32'h77,
                     2'b11, 32'h77, 32'hBBBB0002, 0,1, fw(1,32'h77,3)));
    tv.push_back(mkv(3,1,4,1,0, nul,0, nul,0, fw(1,32'h99,4), 1,3,32'h77,
                     2'b11, 32'hAAAA0001, 32'h99, 0,0, fw(1,32'h99,4)));
    tv.push_back(mkv(6,1,0,0,0, nul,0, fw(0,0,6),0, nul, 0,0,0,
                     2'b11, 32'hAAAA0001, 0, 0,1, nul));
    tv.push_back(mkv(0,0,6,1,0, fw(0,32'h5,6),0, nul,0, fw(1,32'h44,6), 0,0,0,
                     2'b11, 0, 32'h44, 0,0, fw(1,32'h44,6)));

    foreach (tv[i]) begin
      idle();
      id_rs1 = tv[i].rs1; id_rs1_used = tv[i].u1; id_rs2 = tv[i].rs2; id_rs2_used = tv[i].u2;
      flush = tv[i].fl; ex_fwd = tv[i].ex; ex_we = tv[i].exw; mem_fwd = tv[i].mem;
      mem_we = tv[i].memw; wb_fwd = tv[i].wb; lo_cpl_valid = tv[i].cv;
      lo_cpl_rd = tv[i].crd; lo_cpl_data = tv[i].cd;
      settle();
      chk($sformatf("vec%0d_stall", i), stall_if_id, tv[i].e_stall);
      chk($sformatf("vec%0d_bubble", i), bubble_ex, tv[i].e_stall);
      chk($sformatf("vec%0d_ready", i), lo_cpl_ready, tv[i].e_ready);
      chk($sformatf("vec%0d_rf_wr", i), rf_wr, tv[i].e_rf);
      if (tv[i].opmask[0]) chk($sformatf("vec%0d_op1", i), id_op1, tv[i].e_op1);
      if (tv[i].opmask[1]) chk($sformatf("vec%0d_op2", i), id_op2, tv[i].e_op2);
      tick();
    end

    // scoreboard round trip
    idle(); reset = 1; tick(); reset = 0;
    id_long_op = 1; id_rd = 9; id_rd_we = 1;
    settle(); chk("sb_disp_stall", stall_if_id, 0); tick();
    idle(); id_rs1 = 9; id_rs1_used = 1;
    settle();
    chk("sb_bit9", sb_pending, 32'h200);
    chk("sb_busy", sb_busy, 1);
    chk("sb_cons_stall", stall_if_id, 1);
    tick();
    settle(); chk("sb_cons_stall2", stall_if_id, 1); tick();
    lo_cpl_valid = 1; lo_cpl_rd = 9; lo_cpl_data = 32'h55;
    settle();
    chk("sb_grant_stall", stall_if_id, 0);
    chk("sb_grant_op1", id_op1, 32'h55);
    chk("sb_grant_rf", rf_wr, fw(1, 32'h55, 9));
    tick();
    lo_cpl_valid = 0;
    settle();
    chk("sb_cleared", sb_pending, 0);
    chk("sb_not_busy", sb_busy, 0);
    tick();

    // capacity and WAW
    for (int r = 1; r <= 4; r++) begin
      idle(); id_long_op = 1; id_rd = 5'(r); id_rd_we = 1;
      settle(); chk($sformatf("cap_disp%0d", r), stall_if_id, 0); tick();
    end
    idle(); id_long_op = 1; id_rd = 5; id_rd_we = 1;
    settle();
    chk("cap_full_stall", stall_if_id, 1);
    chk("cap_pending", sb_pending, 32'h1E);
    tick();
    lo_cpl_valid = 1; lo_cpl_rd = 1; lo_cpl_data = 32'h101;
    settle(); chk("cap_full_grant_cycle", stall_if_id, 1); tick();
    lo_cpl_valid = 0; id_rd = 2;
    settle();
    chk("waw_stall", stall_if_id, 1);
    chk("waw_pending", sb_pending, 32'h1C);
    tick();

    // reset mid-flight, then a late completion and a full refill
    idle(); reset = 1; tick(); reset = 0;
    settle();
    chk("midrst_pending", sb_pending, 0);
    chk("midrst_busy", sb_busy, 0);
    lo_cpl_valid = 1; lo_cpl_rd = 3; lo_cpl_data = 32'h333;
    settle();
    chk("midrst_cpl_rf", rf_wr, fw(1, 32'h333, 3));
    chk("midrst_cpl_ready", lo_cpl_ready, 1);
    tick();
    idle(); settle(); chk("midrst_after_cpl", sb_pending, 0);
    for (int r = 1; r <= 4; r++) begin
      idle(); id_long_op = 1; id_rd = 5'(r); id_rd_we = 1;
      settle(); chk($sformatf("refill%0d", r), stall_if_id, 0); tick();
    end
    id_rd = 6; settle(); chk("refill_full", stall_if_id, 1); tick();

    // starvation
    idle(); reset = 1; tick(); reset = 0;
    wb_fwd = fw(1, 32'h10, 12); lo_cpl_valid = 1; lo_cpl_rd = 20; lo_cpl_data = 32'h66;
    for (int c = 0; c <= SL; c++) begin
      settle();
      chk($sformatf("starve_c%0d", c), stall_if_id, (c == SL));
      chk($sformatf("starve_ready%0d", c), lo_cpl_ready, 0);
      tick();
    end
    wb_fwd = '0;
    settle();
    chk("starve_grant_rf", rf_wr, fw(1, 32'h66, 20));
    chk("starve_grant_ready", lo_cpl_ready, 1);
    chk("starve_grant_stall", stall_if_id, 1);
    tick();
    lo_cpl_valid = 0;
    settle(); chk("starve_release", stall_if_id, 0); tick();

    // random traffic against the reference model
    idle(); reset = 1; tick(); reset = 0;
    m_pend = 0; m_cnt = 0; m_starve = 0; hold = 0; from_q = 0; m_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [31:0]  e1, e2;
      bit           un1, un2, grant, e_stall, disp;
      forwarding::t e_rf;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_rd = 5'($urandom_range(0, 7)); id_rd_we = ($urandom_range(0, 9) != 0);
      id_long_op = ($urandom_range(0, 2) == 0); flush = ($urandom_range(0, 9) == 0);
      ex_fwd = fw(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 7)));
      mem_fwd = fw(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 7)));
      wb_fwd = fw(($urandom_range(0, 4) < 2), $urandom, 5'($urandom_range(0, 7)));
      ex_we = 1'($urandom); mem_we = 1'($urandom);
      rf_rs1_data = $urandom; rf_rs2_data = $urandom;
      if (!hold) begin
        if (m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
          hold = 1; from_q = 1; lo_cpl_rd = m_q[0]; lo_cpl_data = $urandom;
        end else if (m_q.size() == 0 && $urandom_range(0, 19) == 0) begin
          hold = 1; from_q = 0; lo_cpl_rd = 5'($urandom_range(0, 7)); lo_cpl_data = $urandom;
        end
      end
      lo_cpl_valid = hold;
      settle();

      grant = lo_cpl_valid && !wb_fwd.data_valid;
      m_opnd(id_rs1, rf_rs1_data, grant, e1, un1);
      m_opnd(id_rs2, rf_rs2_data, grant, e2, un2);
      e_stall = 0;
      if (id_rs1_used && id_rs1 != 0 &&
          (un1 || (m_pend[id_rs1] && !(grant && lo_cpl_rd == id_rs1)))) e_stall = 1;
      if (id_rs2_used && id_rs2 != 0 &&
          (un2 || (m_pend[id_rs2] && !(grant && lo_cpl_rd == id_rs2)))) e_stall = 1;
      if (id_long_op && id_rd_we && id_rd != 0 && m_pend[id_rd]) e_stall = 1;
      if (id_long_op && m_cnt == MAXO) e_stall = 1;
      if (m_starve == SL) e_stall = 1;
      if (flush) e_stall = 0;
      e_rf = wb_fwd.data_valid ? wb_fwd : (grant ? fw(1, lo_cpl_data, lo_cpl_rd) : '0);

      chk("rnd_stall", stall_if_id, e_stall);
      chk("rnd_bubble", bubble_ex, e_stall);
      chk("rnd_ready", lo_cpl_ready, !wb_fwd.data_valid);
      chk("rnd_rf_wr", rf_wr, e_rf);
      if (!un1) chk("rnd_op1", id_op1, e1);
      if (!un2) chk("rnd_op2", id_op2, e2);
      chk("rnd_pending", sb_pending, m_pend);
      chk("rnd_busy", sb_busy, (m_pend != 0));

      disp = id_long_op && id_rd_we && id_rd != 0 && !e_stall && !flush;
      if (grant && m_pend[lo_cpl_rd]) begin
        m_pend[lo_cpl_rd] = 0;
        m_cnt--;
      end
      if (disp) begin
        m_pend[id_rd] = 1;
        m_cnt++;
        m_q.push_back(id_rd);
      end
      if (lo_cpl_valid && !grant) m_starve = (m_starve == SL) ? SL : m_starve + 1;
      else m_starve = 0;
      if (grant) begin
        if (from_q) void'(m_q.pop_front());
        hold = 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
